vec4_unpack: RTL and testbench
==============================

VEC4_UNPACK -- requirements
Module: vec4_unpack

Interface
REQ-001 SHALL have parameters: TILE_SIZE, default 4, lanes per input vector; DATA_W, default 16, bits per lane (Q0.16 unsigned sigmoid output); FRAME_VECS, default 16, vectors per frame (used only with the Configuration feature).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream vector valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts a vector this cycle.
REQ-006 SHALL have port in_vec, input, TILE_SIZE x DATA_W unpacked array [TILE_SIZE-1:0], input vector with lane 0 at index 0.
REQ-007 SHALL have port out_valid, output, 1, scalar valid.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts the scalar.
REQ-009 SHALL have port out_data, output, DATA_W, current scalar.
REQ-010 SHALL have port out_last, output, 1, final scalar of a frame; present only when SIGMOID_UNPACK_LAST_EN is defined.

Function
REQ-011 SHALL define in_fire = in_valid && in_ready, and out_fire = out_valid && out_ready.
REQ-012 SHALL hold one vector register, a hold_valid flag and a lane index lane_idx with range 0..TILE_SIZE-1.
REQ-013 SHALL run a two-state FSM: EMPTY (hold_valid=0) and DRAIN (hold_valid=1).
REQ-014 SHALL, on in_fire, capture in_vec, set lane_idx=0 and enter DRAIN.
REQ-015 SHALL drive out_valid=hold_valid and out_data=held lane[lane_idx], both from registers, with no combinational path from in_vec.
REQ-016 SHALL, on out_fire with lane_idx<TILE_SIZE-1, increment lane_idx and stay in DRAIN.
REQ-017 SHALL, on out_fire with lane_idx=TILE_SIZE-1, go to EMPTY, or reload from in_vec in the same cycle (lane_idx=0, stay in DRAIN) if in_fire occurs.
REQ-018 SHALL drive in_ready = rst_n && (!hold_valid || (out_ready && lane_idx==TILE_SIZE-1)).
REQ-019 SHALL have a latency of 1 cycle from in_fire to lane 0 with out_valid=1.
REQ-020 SHALL sustain one scalar per cycle with no bubbles when in_valid and out_ready are held at 1, i.e. one vector every TILE_SIZE cycles.
REQ-021 SHALL, while out_ready=0, hold out_data, out_valid and lane_idx stable, and SHALL never drop or duplicate a lane.
REQ-022 SHALL emit lanes strictly in order 0..TILE_SIZE-1.
REQ-023 SHALL pass data bit-exact with no arithmetic on it.
REQ-024 SHALL ignore in_vec when in_fire=0.

Reset
REQ-025 SHALL, while rst_n=0, force hold_valid=0 (FSM in EMPTY), lane_idx=0, vector register=0, frame counter=0, out_valid=0, out_data=0, in_ready=0, and out_last=0 if present.
REQ-026 SHALL, on reset assertion mid-DRAIN, discard the held vector immediately, with no partial output after release.
REQ-027 SHALL raise in_ready in the first cycle with rst_n=1.

Configuration
REQ-028 SHALL use macro SIGMOID_UNPACK_LAST_EN.
REQ-029 SHALL, when SIGMOID_UNPACK_LAST_EN is defined, keep a vector counter 0..FRAME_VECS-1 that increments on the out_fire of lane TILE_SIZE-1 and wraps to 0 after FRAME_VECS-1.
REQ-030 SHALL, when SIGMOID_UNPACK_LAST_EN is defined, assert out_last=1 exactly when out_valid && lane_idx==TILE_SIZE-1 && counter==FRAME_VECS-1.
REQ-031 SHALL, when SIGMOID_UNPACK_LAST_EN is undefined, have no out_last port and no counter, with all other behaviour identical.

Verification
REQ-032 SHALL cover: single vector {0x0100,0x0200,0x0300,0x0400}, out_ready=1 -> out_data 0x0100,0x0200,0x0300,0x0400 on cycles 1..4 after in_fire, then out_valid=0.
REQ-033 SHALL cover: 3 back-to-back vectors, in_valid=1, out_ready=1 -> 12 consecutive out_valid cycles, no gap, in_ready=1 only on the cycle of each lane-3 out_fire.
REQ-034 SHALL cover: out_ready=0 for 5 cycles while lane 1=0xBEEF is presented -> out_data stays 0xBEEF, in_ready=0, and lanes 2 and 3 follow once out_ready=1.
REQ-035 SHALL cover: rst_n pulsed low while lane 2 is presented -> out_valid=0 and out_data=0 at once, in_ready=1 after release, and the next vector starts at lane 0.
REQ-036 SHALL cover: SIGMOID_UNPACK_LAST_EN with FRAME_VECS=2 and 4 vectors streamed -> out_last=1 only on scalars 8 and 16.
REQ-037 SHALL cover: random in_valid/out_ready at 50% over 1000 vectors -> output sequence equals the input lanes in order, with zero loss.

Source files
------------

// File: rtl/vec4_unpack.sv
// rtl/vec4_unpack.sv - vector-to-scalar unpacker, one held vector drained lane 0 first
// Optional SIGMOID_UNPACK_LAST_EN adds a frame counter and the out_last port.
module vec4_unpack #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_W     = 16,
  parameter int FRAME_VECS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_vec [TILE_SIZE-1:0],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef SIGMOID_UNPACK_LAST_EN
  ,
  output logic              out_last
`endif
);

  localparam int IDX_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(TILE_SIZE - 1);

  if (TILE_SIZE < 2 || FRAME_VECS < 1) begin : g_bad_params
    $error("vec4_unpack: TILE_SIZE must be >= 2 and FRAME_VECS >= 1");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  lane_q, lane_d;
  logic              load;
  logic [DATA_W-1:0] vec_q [TILE_SIZE-1:0];

  logic hold_valid;
  logic last_lane;
  logic in_fire;
  logic out_fire;

  assign hold_valid = (state_q == DRAIN);
  assign last_lane  = (lane_q == LAST_LANE);
  // A new vector may enter in the same cycle the final lane leaves.
  assign in_ready   = rst_n && (!hold_valid || (out_ready && last_lane));
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;

  assign out_valid  = hold_valid;
  assign out_data   = vec_q[lane_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = DRAIN;
          lane_d  = '0;
          load    = 1'b1;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (!last_lane) begin
            lane_d = lane_q + IDX_W'(1);
          end else if (in_fire) begin
            lane_d = '0;
            load   = 1'b1;
          end else begin
            state_d = EMPTY;
            lane_d  = '0;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        lane_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '{default: '0};
    end else if (load) begin
      vec_q <= in_vec;
    end
  end

`ifdef SIGMOID_UNPACK_LAST_EN
  localparam int CNT_W = (FRAME_VECS > 1) ? $clog2(FRAME_VECS) : 1;
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(FRAME_VECS - 1);

  logic [CNT_W-1:0] vec_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_q <= '0;
    end else if (out_fire && last_lane) begin
      vec_cnt_q <= (vec_cnt_q == LAST_VEC) ? '0 : vec_cnt_q + CNT_W'(1);
    end
  end

  assign out_last = hold_valid && last_lane && (vec_cnt_q == LAST_VEC);
`endif

endmodule

// File: tb/tb_vec4_unpack.sv
// tb/tb_vec4_unpack.sv - self-checking bench for vec4_unpack (table vectors + scoreboard)
module tb_vec4_unpack;

  localparam int TS = 4;
  localparam int DW = 16;
  localparam int FV = 2;

  typedef logic [TS-1:0][DW-1:0] lanes_t;
  typedef struct packed {
    lanes_t vin;
    lanes_t exp;
  } vec_rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_vec [TS-1:0];
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef SIGMOID_UNPACK_LAST_EN
  logic          out_last;
`endif

  always #5 clk = ~clk;

  vec4_unpack #(
    .TILE_SIZE (TS),
    .DATA_W    (DW),
    .FRAME_VECS(FV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef SIGMOID_UNPACK_LAST_EN
    ,
    .out_last (out_last)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic lanes_t mk(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                input logic [DW-1:0] a2, input logic [DW-1:0] a3);
    lanes_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    return v;
  endfunction

  task automatic set_vec(input lanes_t v);
    for (int i = 0; i < TS; i++) in_vec[i] = v[i];
  endtask

  // Scoreboard: lanes queued on every accepted vector, popped on every output beat.
  logic [DW-1:0] sb [$];
  int n_in = 0;
  int n_out = 0;
  int lane_pos = 0;

  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      sb.delete();
      lane_pos = 0;
    end else begin
      if (in_valid && in_ready) begin
        for (int i = 0; i < TS; i++) sb.push_back(in_vec[i]);
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got output 0x%0h, expected no output at %0t", out_data, $time);
        end else begin
          chk("sb_data", 32'(out_data), 32'(sb.pop_front()));
        end
`ifdef SIGMOID_UNPACK_LAST_EN
        chk("sb_last", 32'(out_last), 32'(lane_pos == TS * FV - 1));
`endif
        lane_pos = (lane_pos + 1) % (TS * FV);
        n_out++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_rec_t tbl [3];

  initial begin
    int cyc;
    int in0;
    int out0;

    tbl[0].vin = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    tbl[0].exp = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    tbl[1].vin = mk(16'hFFFF, 16'h0000, 16'h8000, 16'h0001);
    tbl[1].exp = mk(16'hFFFF, 16'h0000, 16'h8000, 16'h0001);
    tbl[2].vin = mk(16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678);
    tbl[2].exp = mk(16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678);

    set_vec(mk(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA));
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    // Single vectors: lane k appears k+1 cycles after acceptance, then idle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_vec(tbl[k].vin);
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("single_in_ready", 32'(in_ready), 1);
      for (int l = 0; l < TS; l++) begin
        @(negedge clk);
        in_valid = 1'b0;
        set_vec(mk(16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h5A5A));
        #1;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data", 32'(out_data), 32'(tbl[k].exp[l]));
      end
      @(negedge clk);
      #1;
      chk("single_idle", 32'(out_valid), 0);
    end

    // Three back-to-back vectors: 12 beats without gaps, in_ready only at lane 3.
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = (c < 12);
      set_vec(mk(16'(16'h1000 + c), 16'(16'h2000 + c), 16'(16'h3000 + c), 16'(16'h4000 + c)));
      out_ready = 1'b1;
      #1;
      if (c <= 12) begin
        chk("b2b_valid", 32'(out_valid), 32'(c != 0));
        chk("b2b_in_ready", 32'(in_ready), 32'(c % 4 == 0));
      end else begin
        chk("b2b_idle", 32'(out_valid), 0);
      end
    end

    // Back-pressure on lane 1.
    @(negedge clk);
    set_vec(mk(16'h1111, 16'hBEEF, 16'h2222, 16'h3333));
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("stall_lane0", 32'(out_data), 32'h1111);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_vec(mk(16'h9999, 16'h9999, 16'h9999, 16'h9999));
    repeat (5) begin
      #1;
      chk("stall_data", 32'(out_data), 32'hBEEF);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("stall_resume1", 32'(out_data), 32'hBEEF);
    @(negedge clk);
    #1;
    chk("stall_lane2", 32'(out_data), 32'h2222);
    @(negedge clk);
    #1;
    chk("stall_lane3", 32'(out_data), 32'h3333);
    @(negedge clk);
    #1;
    chk("stall_idle", 32'(out_valid), 0);

    // Reset while lane 2 is presented.
    @(negedge clk);
    set_vec(mk(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D));
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_lane2", 32'(out_data), 32'h0C0C);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", 32'(in_ready), 1);
    chk("mid_rel_valid", 32'(out_valid), 0);
    @(negedge clk);
    #1;
    chk("mid_no_partial", 32'(out_valid), 0);
    set_vec(mk(16'h7001, 16'h7002, 16'h7003, 16'h7004));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid_next_lane0", 32'(out_data), 32'h7001);
    chk("mid_next_valid", 32'(out_valid), 1);
    repeat (4) @(negedge clk);

    // Random handshakes over 1000 vectors.
    in0 = n_in;
    out0 = n_out;
    cyc = 0;
    while (((n_in - in0) < 1000 || sb.size() != 0) && cyc < 40000) begin
      @(negedge clk);
      in_valid = ((n_in - in0) < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < TS; i++) in_vec[i] = DW'($urandom);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_no_timeout", 32'(cyc < 40000), 1);
    chk("rand_vectors_in", 32'(n_in - in0), 1000);
    chk("rand_lanes_out", 32'(n_out - out0), 4000);
    chk("rand_sb_empty", 32'(sb.size()), 0);

`ifdef SIGMOID_UNPACK_LAST_EN
    // Frame marker: with two vectors per frame, last flags scalars 8 and 16.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = (c < 16);
      set_vec(mk(16'(c), 16'(c + 1), 16'(c + 2), 16'(c + 3)));
      out_ready = 1'b1;
      #1;
      chk("frame_last", 32'(out_last), 32'(c == 8 || c == 16));
    end
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
